// File: rtl/bj_card_dealer_pkg.sv
// Shared constants and FSM encoding for the card dealer.
// Build macro ACE_SOFT_EN selects the ace value (11 with soft demotion, else 1).
package bj_card_dealer_pkg;

    localparam logic [3:0] RANK_ACE    = 4'd1;
    localparam logic [3:0] RANK_JACK   = 4'd11;
    localparam logic [3:0] RANK_KING   = 4'd13;
    localparam logic [3:0] FACE_POINTS = 4'd10;
    localparam logic [5:0] BJ_LIMIT    = 6'd21;

`ifdef ACE_SOFT_EN
    localparam logic [3:0] ACE_POINTS  = 4'd11;
`else
    localparam logic [3:0] ACE_POINTS  = 4'd1;
`endif

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_ADD    = 3'd2,
        ST_ADJUST = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

endpackage

// File: rtl/bj_card_dealer_if.sv
// Controller and deck-port signals of the card dealer.
// Names are seen from the dealer: i_* flow into it, o_* flow out of it.
interface bj_card_dealer_if #(
    parameter int HAND_W = 6,
    parameter int RANK_W = 4,
    parameter int CNT_W  = 4
);
    logic              i_NewGame;
    logic              i_Card2Player;
    logic              i_Card2Dealer;
    logic              o_CardOK;
    logic [HAND_W-1:0] o_HandP;
    logic [HAND_W-1:0] o_HandD;
    logic [CNT_W-1:0]  o_CntP;
    logic [CNT_W-1:0]  o_CntD;
    logic              o_DeckRd;
    logic              i_DeckValid;
    logic [RANK_W-1:0] i_DeckRank;
    logic              o_BadCard;

    modport slave (
        input  i_NewGame, i_Card2Player, i_Card2Dealer, i_DeckValid, i_DeckRank,
        output o_CardOK, o_HandP, o_HandD, o_CntP, o_CntD, o_DeckRd, o_BadCard
    );

    modport master (
        output i_NewGame, i_Card2Player, i_Card2Dealer, i_DeckValid, i_DeckRank,
        input  o_CardOK, o_HandP, o_HandD, o_CntP, o_CntD, o_DeckRd, o_BadCard
    );
endinterface

// File: rtl/bj_card_dealer_card_value.sv
// Combinational rank decoder: blackjack points, ace flag and invalid-rank flag.
// Ace points follow ACE_SOFT_EN through the package.
module bj_card_value
    import bj_card_dealer_pkg::*;
#(
    parameter int RANK_W = 4
) (
    input  logic [RANK_W-1:0] i_Rank,
    output logic [3:0]        o_Points,
    output logic              o_IsAce,
    output logic              o_Bad
);

    // Rank to points lookup; invalid ranks score nothing
    always_comb begin
        o_Points = 4'd0;
        o_IsAce  = 1'b0;
        o_Bad    = 1'b0;
        if ((i_Rank == {RANK_W{1'b0}}) || (i_Rank > RANK_W'(RANK_KING))) begin
            o_Bad = 1'b1;
        end else if (i_Rank == RANK_W'(RANK_ACE)) begin
            o_IsAce  = 1'b1;
            o_Points = ACE_POINTS;
        end else if (i_Rank >= RANK_W'(RANK_JACK)) begin
            o_Points = FACE_POINTS;
        end else begin
            o_Points = 4'(i_Rank);
        end
    end

endmodule

// File: rtl/bj_card_dealer.sv
// Card-request responder: serves one player/dealer card per transaction from the deck port.
// Build macro ACE_SOFT_EN: aces count 11 with soft-ace demotion (default build: ace = 1).
module bj_card_dealer
    import bj_card_dealer_pkg::*;
#(
    parameter int HAND_W = 6,
    parameter int RANK_W = 4,
    parameter int CNT_W  = 4
) (
    input  logic            i_Clk,
    input  logic            i_Rst_n,
    bj_card_dealer_if.slave bus
);

    state_t            r_state;
    state_t            w_next;
    logic              r_to_dealer;
    logic [3:0]        r_points;
    logic [HAND_W-1:0] r_hand_p, r_hand_d;
    logic [CNT_W-1:0]  r_cnt_p, r_cnt_d;
    logic              r_card_ok, r_deck_rd, r_bad_card;
    logic [3:0]        w_points;
    logic              w_is_ace, w_bad, w_req, w_xfer, w_demote;
    logic [HAND_W-1:0] w_hand_sel, w_hand_new;
    logic [CNT_W-1:0]  w_cnt_sel, w_cnt_new;
`ifdef ACE_SOFT_EN
    logic              r_is_ace;
    logic [CNT_W-1:0]  r_soft_p, r_soft_d;
    logic [CNT_W-1:0]  w_soft_sel, w_soft_new;
`else
    logic              w_unused_ace;
`endif

    function automatic logic [HAND_W-1:0] hand_add(input logic [HAND_W-1:0] a,
                                                   input logic [3:0] b);
        logic [HAND_W:0] s;
        s = {1'b0, a} + {{(HAND_W-3){1'b0}}, b};
        return s[HAND_W] ? {HAND_W{1'b1}} : s[HAND_W-1:0];
    endfunction

    function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] c);
        return (c == {CNT_W{1'b1}}) ? c : c + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    bj_card_value #(.RANK_W(RANK_W)) u_value (
        .i_Rank   (bus.i_DeckRank),
        .o_Points (w_points),
        .o_IsAce  (w_is_ace),
        .o_Bad    (w_bad)
    );

    assign w_req      = bus.i_Card2Player | bus.i_Card2Dealer;
    assign w_xfer     = r_deck_rd & bus.i_DeckValid;
    assign w_hand_sel = r_to_dealer ? r_hand_d : r_hand_p;
    assign w_cnt_sel  = r_to_dealer ? r_cnt_d  : r_cnt_p;

`ifdef ACE_SOFT_EN
    assign w_soft_sel = r_to_dealer ? r_soft_d : r_soft_p;
    assign w_demote   = (w_hand_sel > HAND_W'(BJ_LIMIT)) && (w_soft_sel != {CNT_W{1'b0}});
`else
    assign w_unused_ace = w_is_ace;
    assign w_demote     = 1'b0;
`endif

    // State register
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; a new game overrides every state
    always_comb begin
        w_next = r_state;
        if (bus.i_NewGame) begin
            w_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:   w_next = w_req ? ST_FETCH : ST_IDLE;
                ST_FETCH:  w_next = w_xfer ? ST_ADD : ST_FETCH;
                ST_ADD:    w_next = ST_ADJUST;
                ST_ADJUST: w_next = ST_DONE;
                ST_DONE:   w_next = ST_IDLE;
                default:   w_next = ST_IDLE;
            endcase
        end
    end

    // Updated value of the hand being served (add in ADD, ace demotion in ADJUST)
    always_comb begin
        w_hand_new = w_hand_sel;
        w_cnt_new  = w_cnt_sel;
`ifdef ACE_SOFT_EN
        w_soft_new = w_soft_sel;
`endif
        if (r_state == ST_ADD) begin
            w_hand_new = hand_add(w_hand_sel, r_points);
            w_cnt_new  = cnt_inc(w_cnt_sel);
`ifdef ACE_SOFT_EN
            w_soft_new = r_is_ace ? cnt_inc(w_soft_sel) : w_soft_sel;
`endif
        end else if ((r_state == ST_ADJUST) && w_demote) begin
            w_hand_new = w_hand_sel - HAND_W'(FACE_POINTS);
`ifdef ACE_SOFT_EN
            w_soft_new = w_soft_sel - {{(CNT_W-1){1'b0}}, 1'b1};
`endif
        end else begin
            w_hand_new = w_hand_sel;
        end
    end

    // Datapath and registered outputs
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            r_to_dealer <= 1'b0;
            r_points    <= 4'd0;
            r_hand_p    <= {HAND_W{1'b0}};
            r_hand_d    <= {HAND_W{1'b0}};
            r_cnt_p     <= {CNT_W{1'b0}};
            r_cnt_d     <= {CNT_W{1'b0}};
            r_card_ok   <= 1'b0;
            r_deck_rd   <= 1'b0;
            r_bad_card  <= 1'b0;
`ifdef ACE_SOFT_EN
            r_is_ace    <= 1'b0;
            r_soft_p    <= {CNT_W{1'b0}};
            r_soft_d    <= {CNT_W{1'b0}};
`endif
        end else if (bus.i_NewGame) begin
            r_points    <= 4'd0;
            r_hand_p    <= {HAND_W{1'b0}};
            r_hand_d    <= {HAND_W{1'b0}};
            r_cnt_p     <= {CNT_W{1'b0}};
            r_cnt_d     <= {CNT_W{1'b0}};
            r_card_ok   <= 1'b0;
            r_deck_rd   <= 1'b0;
            r_bad_card  <= 1'b0;
`ifdef ACE_SOFT_EN
            r_is_ace    <= 1'b0;
            r_soft_p    <= {CNT_W{1'b0}};
            r_soft_d    <= {CNT_W{1'b0}};
`endif
        end else begin
            r_card_ok  <= (w_next == ST_DONE);
            r_deck_rd  <= (w_next == ST_FETCH);
            r_bad_card <= w_xfer & w_bad;
            if ((r_state == ST_IDLE) && w_req) begin
                r_to_dealer <= ~bus.i_Card2Player;
            end
            if (w_xfer) begin
                r_points <= w_points;
`ifdef ACE_SOFT_EN
                r_is_ace <= w_is_ace;
`endif
            end
            if ((r_state == ST_ADD) || (r_state == ST_ADJUST)) begin
                if (r_to_dealer) begin
                    r_hand_d <= w_hand_new;
                    r_cnt_d  <= w_cnt_new;
`ifdef ACE_SOFT_EN
                    r_soft_d <= w_soft_new;
`endif
                end else begin
                    r_hand_p <= w_hand_new;
                    r_cnt_p  <= w_cnt_new;
`ifdef ACE_SOFT_EN
                    r_soft_p <= w_soft_new;
`endif
                end
            end
        end
    end

    assign bus.o_CardOK  = r_card_ok;
    assign bus.o_DeckRd  = r_deck_rd;
    assign bus.o_BadCard = r_bad_card;
    assign bus.o_HandP   = r_hand_p;
    assign bus.o_HandD   = r_hand_d;
    assign bus.o_CntP    = r_cnt_p;
    assign bus.o_CntD    = r_cnt_d;

endmodule

// File: tb/tb_bj_card_dealer.sv
// Scoreboard bench for bj_card_dealer: expected hands are queued when a card is
// requested and compared when o_CardOK appears. Honours ACE_SOFT_EN.
module tb_bj_card_dealer;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    bj_card_dealer_if bus ();

    bj_card_dealer dut (
        .i_Clk   (clk),
        .i_Rst_n (rst_n),
        .bus     (bus)
    );

`ifdef ACE_SOFT_EN
    localparam int ACE_PTS = 11;
    localparam bit SOFT    = 1'b1;
`else
    localparam int ACE_PTS = 1;
    localparam bit SOFT    = 1'b0;
`endif

    typedef struct {
        int hp;
        int hd;
        int cp;
        int cd;
        int bad;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   ok_cnt   = 0;
    int   bad_cnt  = 0;
    int   ok0;
    int   m_hp, m_hd, m_cp, m_cd, m_sp, m_sd;

    always @(negedge clk) begin
        if (bus.o_CardOK === 1'b1) ok_cnt++;
        if (bus.o_BadCard === 1'b1) bad_cnt++;
    end

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_hp = 0; m_hd = 0; m_cp = 0; m_cd = 0; m_sp = 0; m_sd = 0;
    endtask

    // Reference hand arithmetic straight from the game rules
    task automatic model_card(input bit to_d, input int rank, output exp_t e);
        int pts, ace, h, c, s;
        ace = 0;
        e.bad = 0;
        if (rank == 0 || rank > 13) begin pts = 0; e.bad = 1; end
        else if (rank == 1) begin pts = ACE_PTS; ace = 1; end
        else if (rank > 10) pts = 10;
        else pts = rank;
        h = to_d ? m_hd : m_hp;
        c = to_d ? m_cd : m_cp;
        s = to_d ? m_sd : m_sp;
        h = (h + pts > 63) ? 63 : h + pts;
        c = (c + 1 > 15) ? 15 : c + 1;
        s = s + ace;
        if (SOFT && h > 21 && s > 0) begin h = h - 10; s = s - 1; end
        if (to_d) begin m_hd = h; m_cd = c; m_sd = s; end
        else begin m_hp = h; m_cp = c; m_sp = s; end
        e.hp = m_hp; e.hd = m_hd; e.cp = m_cp; e.cd = m_cd;
    endtask

    task automatic new_game();
        bus.i_NewGame = 1'b1;
        @(posedge clk); #1;
        bus.i_NewGame = 1'b0;
        model_clear();
    endtask

    // One card transaction; the deck withholds valid for 'stall' FETCH cycles
    task automatic deal(input bit to_d, input bit both, input int rank, input int stall);
        exp_t e;
        int   lat, rd, b0;
        bit   seen;
        model_card(to_d && !both, rank, e);
        sb_q.push_back(e);
        b0 = bad_cnt; lat = 0; rd = 0; seen = 1'b0;
        bus.i_Card2Player = !to_d || both;
        bus.i_Card2Dealer = to_d || both;
        bus.i_DeckRank    = 4'(rank);
        bus.i_DeckValid   = 1'b0;
        while (!seen && lat < 60) begin
            @(posedge clk); #1;
            lat++;
            if (bus.o_DeckRd === 1'b1) rd++;
            bus.i_DeckValid = (bus.o_DeckRd === 1'b1) && (rd > stall);
            seen = (bus.o_CardOK === 1'b1);
        end
        check_val("cardok_seen", 32'(seen), 32'd1);
        e = sb_q.pop_front();
        if (seen) begin
            check_val("latency", lat, 4 + stall);
            check_val("deckrd_cycles", rd, stall + 1);
            check_val("hand_p", bus.o_HandP, e.hp);
            check_val("hand_d", bus.o_HandD, e.hd);
            check_val("cnt_p", bus.o_CntP, e.cp);
            check_val("cnt_d", bus.o_CntD, e.cd);
            check_val("badcard_pulses", bad_cnt - b0, e.bad);
        end
        bus.i_DeckValid = 1'b0;
        @(posedge clk); #1;
        check_val("cardok_one_cycle", bus.o_CardOK, 32'd0);
        check_val("idle_after_done", bus.o_DeckRd, 32'd0);
        bus.i_Card2Player = 1'b0;
        bus.i_Card2Dealer = 1'b0;
        @(posedge clk); #1;
        check_val("no_stale_reserve", bus.o_DeckRd, 32'd0);
    endtask

    initial begin
        rst_n             = 1'b0;
        bus.i_NewGame     = 1'b0;
        bus.i_Card2Player = 1'b0;
        bus.i_Card2Dealer = 1'b0;
        bus.i_DeckValid   = 1'b0;
        bus.i_DeckRank    = 4'd0;
        model_clear();
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_cardok", bus.o_CardOK, 32'd0);
        check_val("rst_deckrd", bus.o_DeckRd, 32'd0);
        check_val("rst_badcard", bus.o_BadCard, 32'd0);
        check_val("rst_hand_p", bus.o_HandP, 32'd0);
        check_val("rst_hand_d", bus.o_HandD, 32'd0);
        check_val("rst_cnt_p", bus.o_CntP, 32'd0);
        check_val("rst_cnt_d", bus.o_CntD, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Single card, deck ready
        deal(1'b0, 1'b0, 7, 0);
        check_val("first_hand_p", bus.o_HandP, 32'd7);
        check_val("first_cnt_p", bus.o_CntP, 32'd1);

        // Alternating deal with a dealer ace
        new_game();
        ok0 = ok_cnt;
        deal(1'b0, 1'b0, 10, 0);
        deal(1'b1, 1'b0, 1, 0);
        deal(1'b0, 1'b0, 13, 0);
        deal(1'b1, 1'b0, 9, 0);
        check_val("seq_hand_p", bus.o_HandP, 32'd20);
        check_val("seq_hand_d", bus.o_HandD, SOFT ? 32'd20 : 32'd10);
        check_val("seq_cardok_count", ok_cnt - ok0, 32'd4);

        // Two aces then nine: soft demotion
        new_game();
        deal(1'b0, 1'b0, 1, 0);
        check_val("ace1_hand_p", bus.o_HandP, SOFT ? 32'd11 : 32'd1);
        deal(1'b0, 1'b0, 1, 0);
        check_val("ace2_hand_p", bus.o_HandP, SOFT ? 32'd12 : 32'd2);
        deal(1'b0, 1'b0, 9, 0);
        check_val("ace9_hand_p", bus.o_HandP, SOFT ? 32'd21 : 32'd11);

        // Both requests, deck stalls five cycles
        new_game();
        ok0 = ok_cnt;
        deal(1'b0, 1'b1, 6, 5);
        check_val("prio_hand_p", bus.o_HandP, 32'd6);
        check_val("prio_hand_d", bus.o_HandD, 32'd0);
        check_val("prio_cardok_count", ok_cnt - ok0, 32'd1);

        // New game in ADD aborts the card in flight
        ok0 = ok_cnt;
        bus.i_Card2Dealer = 1'b1;
        bus.i_DeckRank    = 4'd5;
        bus.i_DeckValid   = 1'b1;
        @(posedge clk); #1;
        check_val("abort_fetch", bus.o_DeckRd, 32'd1);
        @(posedge clk); #1;
        bus.i_NewGame     = 1'b1;
        bus.i_Card2Dealer = 1'b0;
        @(posedge clk); #1;
        bus.i_NewGame   = 1'b0;
        bus.i_DeckValid = 1'b0;
        model_clear();
        repeat (6) @(posedge clk);
        #1;
        check_val("abort_no_cardok", ok_cnt - ok0, 32'd0);
        check_val("abort_hand_p", bus.o_HandP, 32'd0);
        check_val("abort_hand_d", bus.o_HandD, 32'd0);
        check_val("abort_cnt_d", bus.o_CntD, 32'd0);
        deal(1'b1, 1'b0, 8, 0);
        check_val("post_abort_hand_d", bus.o_HandD, 32'd8);

        // Invalid ranks count a card but add no points
        deal(1'b0, 1'b0, 14, 0);
        deal(1'b0, 1'b0, 0, 0);
        deal(1'b0, 1'b0, 5, 1);
        check_val("bad_hand_p", bus.o_HandP, 32'd5);
        check_val("bad_cnt_p", bus.o_CntP, 32'd3);

        // Hand and count saturation
        new_game();
        for (int i = 0; i < 16; i++) deal(1'b0, 1'b0, 10, 0);
        check_val("sat_hand_p", bus.o_HandP, 32'd63);
        check_val("sat_cnt_p", bus.o_CntP, 32'd15);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
